// File: rtl/program_counter_if.sv
// Program counter control/data bundle.
// Ports: inc, load, in (to the PC), out (from the PC).
interface program_counter_if #(
   parameter int WIDTH = 16
);
   logic             inc;
   logic             load;
   logic [WIDTH-1:0] in;
   logic [WIDTH-1:0] out;

   modport master (
      output inc,
      output load,
      output in,
      input  out
   );

   modport slave (
      input  inc,
      input  load,
      input  in,
      output out
   );
endinterface

// File: rtl/program_counter.sv
// Program counter: loads a jump target, increments, or holds each edge.
// Ports: clk, reset (async, active-low), pc (slave: inc, load, in -> out).
module program_counter #(
   parameter int               WIDTH       = 16,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input logic             clk,
   input logic             reset,
   program_counter_if.slave pc
);

   logic [WIDTH-1:0] pc_d;
   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] pc_inc;
   logic [WIDTH-1:0] carry;

   // Ripple half-adder chain; the final carry-out is dropped so the
   // increment wraps modulo 2^WIDTH.
   assign carry[0] = 1'b1;

   for (genvar i = 0; i < WIDTH; i++) begin : g_ha
      assign pc_inc[i] = pc_q[i] ^ carry[i];
      if (i < WIDTH - 1) begin : g_c
         assign carry[i+1] = pc_q[i] & carry[i];
      end
   end

   // Load wins over increment.
   always_comb begin
      pc_d = pc_q;
      if (pc.load) begin
         pc_d = pc.in;
      end else if (pc.inc) begin
         pc_d = pc_inc;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q <= RESET_VALUE;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc.out = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Testbench for program_counter: directed plan plus random stimulus.
// Checks out against a simple arithmetic model of the PC.
module tb_program_counter;

   logic clk;
   logic reset;
   logic clk_en;

   int n_vec;
   int n_err;
   longint m_pc;

   program_counter_if #(.WIDTH(16)) pc_if ();

   program_counter #(
      .WIDTH(16),
      .RESET_VALUE(16'h0000)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .pc   (pc_if.slave)
   );

   initial begin
      clk = 1'b0;
      wait (clk_en);
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [15:0] got,
                      input longint exp);
      logic [15:0] e;
      e = 16'(exp);
      n_vec++;
      if (got !== e) begin
         n_err++;
         $display("FAIL %s: out=%h expected=%h at %0t", tag, got, e, $time);
      end
   endtask

   // One rising edge, update the model from the spec rules, check at +1.
   task automatic edge_chk(input string tag);
      @(posedge clk);
      if (!reset)
         m_pc = 0;
      else if (pc_if.load)
         m_pc = pc_if.in;
      else if (pc_if.inc)
         m_pc = (m_pc + 1) % 65536;
      #1;
      chk(tag, pc_if.out, m_pc);
   endtask

   task automatic drive(input logic ld, input logic ic,
                        input logic [15:0] d);
      pc_if.load = ld;
      pc_if.inc  = ic;
      pc_if.in   = d;
   endtask

   initial begin
      n_vec  = 0;
      n_err  = 0;
      m_pc   = 0;
      clk_en = 1'b0;
      reset  = 1'b1;
      drive(1'b0, 1'b0, 16'h0);

      // Async reset with the clock idle.
      #2 reset = 1'b0;
      #1 chk("rst_idle", pc_if.out, 0);

      clk_en = 1'b1;
      drive(1'b1, 1'b0, 16'd25);
      for (int i = 0; i < 3; i++) edge_chk("rst_hold");

      #2 reset = 1'b1;
      #1 chk("rst_rel", pc_if.out, 0);

      edge_chk("load25");
      drive(1'b0, 1'b1, 16'd25);
      for (int i = 0; i < 5; i++) edge_chk("count");

      drive(1'b0, 1'b0, 16'd527);
      for (int i = 0; i < 4; i++) edge_chk("hold");
      drive(1'b1, 1'b1, 16'd527);
      edge_chk("ld_prio");
      drive(1'b0, 1'b1, 16'd527);
      edge_chk("inc_after");

      drive(1'b1, 1'b0, 16'hFFFF);
      edge_chk("load_max");
      drive(1'b0, 1'b1, 16'h0);
      edge_chk("wrap0");
      edge_chk("wrap1");

      // Async reset mid-count at 40.
      drive(1'b1, 1'b0, 16'd40);
      edge_chk("load40");
      drive(1'b0, 1'b1, 16'd0);
      #2 reset = 1'b0;
      m_pc = 0;
      #1 chk("rst_mid", pc_if.out, 0);
      @(negedge clk);
      reset = 1'b1;
      #1 chk("rst_rel2", pc_if.out, 0);
      edge_chk("post_rst1");
      edge_chk("post_rst2");

      // Random stimulus, with occasional async reset pulses.
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(3) == 0), ($urandom_range(1) == 1),
               16'($urandom));
         if ($urandom_range(29) == 0) begin
            #1 reset = 1'b0;
            m_pc = 0;
            #1 chk("rnd_rst", pc_if.out, 0);
            if ($urandom_range(1) == 1) edge_chk("rnd_rst_edge");
            @(negedge clk);
            reset = 1'b1;
            #1 chk("rnd_rel", pc_if.out, 0);
         end
         edge_chk("rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
